// File: rtl/fb_output_ramp_sat.sv
// fb_output_ramp_sat: output stage of the pt_feedback path.
// Applies a signed Q(GAIN_FRAC) gain to the adder sum, multiplies by a
// soft-enable envelope that ramps between 0 and 2^ENV_BITS, then clamps the
// result to the signed DAC word and flags clipped samples.
// Optional feature: define FB_OUTPUT_SAT_COUNT_EN to build the saturation
// event counter behind sat_count_o; otherwise sat_count_o is tied to 0.
module fb_output_ramp_sat #(
    parameter int INPUT_WIDTH  = 16,
    parameter int OUTPUT_WIDTH = 14,
    parameter int GAIN_WIDTH   = 16,
    parameter int GAIN_FRAC    = 12,
    parameter int ENV_BITS     = 8,
    parameter int PERIOD_WIDTH = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic signed [INPUT_WIDTH-1:0]  data_i,
    input  logic signed [GAIN_WIDTH-1:0]   gain_i,
    input  logic                           enable_i,
    input  logic        [PERIOD_WIDTH-1:0] ramp_period_i,
    input  logic                           clr_sat_i,
    output logic signed [OUTPUT_WIDTH-1:0] data_o,
    output logic                           sat_o,
    output logic        [1:0]              state_o,
    output logic        [ENV_BITS:0]       env_o,
    output logic        [15:0]             sat_count_o
);

    localparam int P1W   = INPUT_WIDTH + GAIN_WIDTH;
    localparam int P2W   = P1W + ENV_BITS + 1;
    localparam int SHIFT = GAIN_FRAC + ENV_BITS;

    localparam logic [ENV_BITS:0]     ENV_FULL = {1'b1, {ENV_BITS{1'b0}}};
    localparam logic [ENV_BITS:0]     ENV_ZERO = '0;
    localparam logic [ENV_BITS:0]     ENV_ONE  = {{ENV_BITS{1'b0}}, 1'b1};
    localparam logic [PERIOD_WIDTH-1:0] CNT_ONE = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};

    // Clamp limits expressed at the full product width so the compare is exact.
    localparam logic signed [P2W-1:0] OUT_MAX =
        {{(P2W-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [P2W-1:0] OUT_MIN =
        {{(P2W-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_OFF       = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_ON        = 2'd2,
        ST_RAMP_DOWN = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [ENV_BITS:0]        r_env;
    logic [ENV_BITS:0]        w_envNext;
    logic [ENV_BITS:0]        w_envInc;
    logic [ENV_BITS:0]        w_envDec;
    logic [PERIOD_WIDTH-1:0]  r_cnt;
    logic [PERIOD_WIDTH-1:0]  w_cntNext;
    logic                     w_step;

    logic signed [P1W-1:0]    w_dataExt;
    logic signed [P1W-1:0]    w_gainExt;
    logic signed [P1W-1:0]    w_p1;
    logic signed [P1W-1:0]    r_p1;
    logic signed [P2W-1:0]    w_p1Ext;
    logic signed [P2W-1:0]    w_envExt;
    logic signed [P2W-1:0]    w_p2;
    logic signed [P2W-1:0]    r_p2;
    logic signed [P2W-1:0]    w_shifted;
    logic signed [OUTPUT_WIDTH-1:0] w_dataNext;
    logic                     w_satNext;

    // The envelope never wraps: increments stop at full scale, decrements at zero.
    assign w_envInc = (r_env == ENV_FULL) ? ENV_FULL : (r_env + ENV_ONE);
    assign w_envDec = (r_env == ENV_ZERO) ? ENV_ZERO : (r_env - ENV_ONE);
    assign w_step   = (r_cnt == ramp_period_i);

    // State, envelope and step timer registers; reset aborts any ramp at once.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_OFF;
            r_env   <= ENV_ZERO;
            r_cnt   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_env   <= w_envNext;
            r_cnt   <= w_cntNext;
        end
    end

    // Next-state: an enable change always beats a pending step.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_OFF: begin
                if (enable_i) w_stateNext = ST_RAMP_UP;
            end
            ST_RAMP_UP: begin
                if (!enable_i)                          w_stateNext = ST_RAMP_DOWN;
                else if (w_step && w_envInc == ENV_FULL) w_stateNext = ST_ON;
            end
            ST_ON: begin
                if (!enable_i) w_stateNext = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: begin
                if (enable_i)                            w_stateNext = ST_RAMP_UP;
                else if (w_step && w_envDec == ENV_ZERO) w_stateNext = ST_OFF;
            end
            default: w_stateNext = ST_OFF;
        endcase
    end

    // Envelope and step timer updates; the timer restarts on any transition or step.
    always_comb begin
        w_envNext = r_env;
        w_cntNext = '0;
        case (r_state)
            ST_OFF: begin
                w_envNext = ENV_ZERO;
            end
            ST_RAMP_UP: begin
                if (enable_i) begin
                    if (w_step) w_envNext = w_envInc;
                    else        w_cntNext = r_cnt + CNT_ONE;
                end
            end
            ST_ON: begin
                w_envNext = ENV_FULL;
            end
            ST_RAMP_DOWN: begin
                if (!enable_i) begin
                    if (w_step) w_envNext = w_envDec;
                    else        w_cntNext = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_envNext = ENV_ZERO;
            end
        endcase
    end

    assign state_o = r_state;
    assign env_o   = r_env;

    // Datapath operands sign-extended (samples, gain) or zero-extended (envelope)
    // to the product width so the truncated products are exact.
    assign w_dataExt = {{(P1W-INPUT_WIDTH){data_i[INPUT_WIDTH-1]}}, data_i};
    assign w_gainExt = {{(P1W-GAIN_WIDTH){gain_i[GAIN_WIDTH-1]}}, gain_i};
    assign w_p1      = w_dataExt * w_gainExt;
    assign w_p1Ext   = {{(P2W-P1W){r_p1[P1W-1]}}, r_p1};
    assign w_envExt  = {{(P2W-ENV_BITS-1){1'b0}}, r_env};
    assign w_p2      = w_p1Ext * w_envExt;
    assign w_shifted = r_p2 >>> SHIFT;

    // Clamp the rescaled product to the DAC range and flag clipping.
    always_comb begin
        w_satNext  = 1'b0;
        w_dataNext = w_shifted[OUTPUT_WIDTH-1:0];
        if (w_shifted > OUT_MAX) begin
            w_satNext  = 1'b1;
            w_dataNext = OUT_MAX[OUTPUT_WIDTH-1:0];
        end else if (w_shifted < OUT_MIN) begin
            w_satNext  = 1'b1;
            w_dataNext = OUT_MIN[OUTPUT_WIDTH-1:0];
        end
    end

    // Three-stage pipeline: gain product, envelope product, clamped output.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_p1   <= '0;
            r_p2   <= '0;
            data_o <= '0;
            sat_o  <= 1'b0;
        end else begin
            r_p1   <= w_p1;
            r_p2   <= w_p2;
            data_o <= w_dataNext;
            sat_o  <= w_satNext;
        end
    end

`ifdef FB_OUTPUT_SAT_COUNT_EN
    logic [15:0] r_satCount;

    // Count clipped output samples, sticking at all-ones; clear wins over count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_satCount <= '0;
        end else if (clr_sat_i) begin
            r_satCount <= '0;
        end else if (sat_o && (r_satCount != 16'hFFFF)) begin
            r_satCount <= r_satCount + 16'd1;
        end
    end

    assign sat_count_o = r_satCount;
`else
    logic w_unusedClr;
    assign w_unusedClr = clr_sat_i;
    assign sat_count_o = '0;
`endif

endmodule

// File: tb/tb_fb_output_ramp_sat.sv
// tb_fb_output_ramp_sat: scoreboard bench for fb_output_ramp_sat.
// A behavioural model predicts every output cycle and queues the prediction;
// a monitor pops one entry after each clock edge and compares.
module tb_fb_output_ramp_sat;

    localparam int FULL = 256;
    localparam longint SCALE = 64'd1048576;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic signed [15:0] data_i;
    logic signed [15:0] gain_i;
    logic               enable_i;
    logic        [15:0] ramp_period_i;
    logic               clr_sat_i;
    logic signed [13:0] data_o;
    logic               sat_o;
    logic        [1:0]  state_o;
    logic        [8:0]  env_o;
    logic        [15:0] sat_count_o;

    fb_output_ramp_sat dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .data_i       (data_i),
        .gain_i       (gain_i),
        .enable_i     (enable_i),
        .ramp_period_i(ramp_period_i),
        .clr_sat_i    (clr_sat_i),
        .data_o       (data_o),
        .sat_o        (sat_o),
        .state_o      (state_o),
        .env_o        (env_o),
        .sat_count_o  (sat_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int data;
        int sat;
        int st;
        int env;
        int sc;
    } exp_t;

    exp_t expQ[$];
    exp_t popE;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: pipeline contents and envelope controller as plain numbers.
    longint mP1, mP2;
    int     mData, mSat, mState, mEnv, mCnt, mSc;

    logic signed [15:0] rd;
    logic signed [15:0] rg;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d time=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic longint floorDiv(input longint v);
        if (v >= 0) return v / SCALE;
        return -((-v + SCALE - 1) / SCALE);
    endfunction

    task automatic modelReset();
        mP1 = 0; mP2 = 0; mData = 0; mSat = 0;
        mState = 0; mEnv = 0; mCnt = 0; mSc = 0;
    endtask

    // Advance the model by one clock edge given the inputs seen at that edge.
    task automatic modelClock(input int d, input int g, input bit en, input int per, input bit clr);
        longint newP1, newP2, q;
        int newData, newSat, newSc;
        newP1 = longint'(d) * longint'(g);
        newP2 = mP1 * longint'(mEnv);
        q = floorDiv(mP2);
        if (q > 8191)       begin newData = 8191;  newSat = 1; end
        else if (q < -8192) begin newData = -8192; newSat = 1; end
        else                begin newData = int'(q); newSat = 0; end
        if (clr)                          newSc = 0;
        else if (mSat == 1 && mSc < 65535) newSc = mSc + 1;
        else                              newSc = mSc;
        case (mState)
            0: if (en) begin mState = 1; mCnt = 0; end
            1: begin
                if (!en) begin mState = 3; mCnt = 0; end
                else if (mCnt == per) begin
                    mCnt = 0;
                    if (mEnv < FULL) mEnv = mEnv + 1;
                    if (mEnv == FULL) mState = 2;
                end else mCnt = mCnt + 1;
            end
            2: if (!en) begin mState = 3; mCnt = 0; end
            default: begin
                if (en) begin mState = 1; mCnt = 0; end
                else if (mCnt == per) begin
                    mCnt = 0;
                    if (mEnv > 0) mEnv = mEnv - 1;
                    if (mEnv == 0) mState = 0;
                end else mCnt = mCnt + 1;
            end
        endcase
        mP1 = newP1; mP2 = newP2; mData = newData; mSat = newSat; mSc = newSc;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the prediction.
    task automatic applyStimulus(input int d, input int g, input bit en, input int per, input bit clr);
        exp_t e;
        @(negedge clk_i);
        data_i        = d[15:0];
        gain_i        = g[15:0];
        enable_i      = en;
        ramp_period_i = per[15:0];
        clr_sat_i     = clr;
        modelClock(int'(data_i), int'(gain_i), en, int'(ramp_period_i), clr);
        e.data = mData;
        e.sat  = mSat;
        e.st   = mState;
        e.env  = mEnv;
`ifdef FB_OUTPUT_SAT_COUNT_EN
        e.sc   = mSc;
`else
        e.sc   = 0;
`endif
        expQ.push_back(e);
    endtask

    task automatic rampUntil(input int d, input int g, input bit en, input int per,
                             input int stTarget, input int envTarget, input int limit,
                             input string name);
        int n;
        n = 0;
        while (!(mState == stTarget && (envTarget < 0 || mEnv == envTarget)) && n < limit) begin
            applyStimulus(d, g, en, per, 1'b0);
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("[TB] FAIL %s timeout after %0d cycles", name, n);
        end
    endtask

    task automatic checkZeros(input string tag);
        checkOutput({tag, "_data_o"}, longint'(data_o), 0);
        checkOutput({tag, "_sat_o"}, longint'(sat_o), 0);
        checkOutput({tag, "_state_o"}, longint'(state_o), 0);
        checkOutput({tag, "_env_o"}, longint'(env_o), 0);
        checkOutput({tag, "_sat_count_o"}, longint'(sat_count_o), 0);
    endtask

    // Monitor: one prediction per clock edge while the queue holds entries.
    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (expQ.size() > 0) begin
                popE = expQ.pop_front();
                checkOutput("scb_data_o", longint'(data_o), popE.data);
                checkOutput("scb_sat_o", longint'(sat_o), popE.sat);
                checkOutput("scb_state_o", longint'(state_o), popE.st);
                checkOutput("scb_env_o", longint'(env_o), popE.env);
                checkOutput("scb_sat_count_o", longint'(sat_count_o), popE.sc);
            end
        end
    end

    // Directed scenarios followed by randomized segments.
    initial begin
        rst_ni = 1'b0; data_i = '0; gain_i = '0; enable_i = 1'b0;
        ramp_period_i = '0; clr_sat_i = 1'b0;
        modelReset();
        @(posedge clk_i); @(posedge clk_i); #2;
        checkZeros("reset");
        rst_ni = 1'b1;

        // Pass-through at full envelope.
        rampUntil(1000, 4096, 1'b1, 0, 2, -1, 400, "pass_reach_on");
        repeat (4) applyStimulus(1000, 4096, 1'b1, 0, 1'b0);
        checkOutput("pass_pos_data", longint'(data_o), 1000);
        checkOutput("pass_pos_sat", longint'(sat_o), 0);
        checkOutput("pass_env_full", longint'(env_o), 256);
        repeat (4) applyStimulus(-1000, 4096, 1'b1, 0, 1'b0);
        checkOutput("pass_neg_data", longint'(data_o), -1000);

        // Saturation at both rails.
        repeat (4) applyStimulus(32767, 4096, 1'b1, 0, 1'b0);
        checkOutput("sat_pos_data", longint'(data_o), 8191);
        checkOutput("sat_pos_flag", longint'(sat_o), 1);
        repeat (4) applyStimulus(-32768, 4096, 1'b1, 0, 1'b0);
        checkOutput("sat_neg_data", longint'(data_o), -8192);
        checkOutput("sat_neg_flag", longint'(sat_o), 1);
        repeat (4) applyStimulus(0, 4096, 1'b1, 0, 1'b0);
        applyStimulus(0, 4096, 1'b1, 0, 1'b1);
        applyStimulus(32767, 4096, 1'b1, 0, 1'b0);
        applyStimulus(-32768, 4096, 1'b1, 0, 1'b0);
        repeat (4) applyStimulus(0, 4096, 1'b1, 0, 1'b0);
`ifdef FB_OUTPUT_SAT_COUNT_EN
        checkOutput("sat_count_two", longint'(sat_count_o), 2);
`else
        checkOutput("sat_count_tied", longint'(sat_count_o), 0);
`endif
        applyStimulus(0, 4096, 1'b1, 0, 1'b1);
        applyStimulus(0, 4096, 1'b1, 0, 1'b0);
        checkOutput("sat_count_clr", longint'(sat_count_o), 0);

        // Negative gain rounds toward minus infinity.
        repeat (4) applyStimulus(3, -2048, 1'b1, 0, 1'b0);
        checkOutput("neg_gain_floor", longint'(data_o), -2);

        // Slow ramp up with ramp_period_i = 3 from a clean OFF state.
        rampUntil(0, 4096, 1'b0, 0, 0, -1, 400, "off_before_slow");
        repeat (2) applyStimulus(0, 4096, 1'b0, 0, 1'b0);
        for (int k = 1; k <= 1026; k++) begin
            applyStimulus(4000, 4096, 1'b1, 3, 1'b0);
            if (k == 2) begin
                checkOutput("slow_enter_up", longint'(state_o), 1);
                checkOutput("slow_env_start", longint'(env_o), 0);
            end
            if (k == 1025) begin
                checkOutput("slow_before_on_state", longint'(state_o), 1);
                checkOutput("slow_before_on_env", longint'(env_o), 255);
            end
        end
        checkOutput("slow_on_state", longint'(state_o), 2);
        checkOutput("slow_on_env", longint'(env_o), 256);

        // Ramp back down to OFF; output must settle at zero.
        rampUntil(4000, 4096, 1'b0, 0, 0, -1, 400, "down_to_off");
        repeat (4) applyStimulus(4000, 4096, 1'b0, 0, 1'b0);
        checkOutput("off_data_zero", longint'(data_o), 0);
        checkOutput("off_state", longint'(state_o), 0);

        // Reversal: drop enable at env 100, re-raise at env 50 on the way down.
        rampUntil(4000, 4096, 1'b1, 0, 1, 100, 400, "rev_up_100");
        applyStimulus(4000, 4096, 1'b0, 0, 1'b0);
        applyStimulus(4000, 4096, 1'b0, 0, 1'b0);
        checkOutput("rev_down_state", longint'(state_o), 3);
        checkOutput("rev_down_env_kept", longint'(env_o), 100);
        rampUntil(4000, 4096, 1'b0, 0, 3, 50, 400, "rev_down_50");
        applyStimulus(4000, 4096, 1'b1, 0, 1'b0);
        applyStimulus(4000, 4096, 1'b1, 0, 1'b0);
        checkOutput("rev_up_state", longint'(state_o), 1);
        checkOutput("rev_up_env_kept", longint'(env_o), 50);
        rampUntil(4000, 4096, 1'b0, 0, 0, -1, 400, "rev_to_off");
        repeat (4) applyStimulus(4000, 4096, 1'b0, 0, 1'b0);
        checkOutput("rev_off_data", longint'(data_o), 0);

        // Asynchronous reset in the middle of a saturating ramp.
        rampUntil(32767, 4096, 1'b1, 0, 1, 120, 400, "rst_up_120");
        @(posedge clk_i); #2;
        checkOutput("pre_rst_env", longint'(env_o), 120);
        checkOutput("pre_rst_state", longint'(state_o), 1);
        checkOutput("pre_rst_sat", longint'(sat_o), 1);
        rst_ni = 1'b0;
        expQ.delete();
        #1;
        checkZeros("async_rst");
        enable_i = 1'b0;
        @(posedge clk_i); #2;
        checkZeros("held_rst");
        rst_ni = 1'b1;
        checkZeros("release_rst");
        modelReset();

        // Randomized segments of alternating enable with random samples and gains.
        begin
            bit en;
            int total;
            en = 1'b0;
            total = 0;
            while (total < 4000) begin
                int len, per;
                en  = ~en;
                len = $urandom_range(5, 700);
                per = $urandom_range(0, 2);
                for (int c = 0; c < len; c++) begin
                    rd = 16'($urandom_range(0, 65535));
                    if ($urandom_range(0, 1) == 0) rg = 16'($urandom_range(0, 8192));
                    else                           rg = 16'($urandom_range(0, 65535));
                    applyStimulus(int'(rd), int'(rg), en, per, ($urandom_range(0, 39) == 0));
                end
                total += len;
            end
        end

        @(posedge clk_i); #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fb_output_ramp_sat.md
Name: fb_output_ramp_sat

Overview:
- Output stage directly downstream of the 4x1 conditional adder in the pt_feedback path. Consumes its registered 16-bit signed sum.
- Applies a programmable signed gain, then a soft-enable envelope ramp so feedback switches on/off without steps, then saturates to the 14-bit DAC word.
- Reports ramp state and saturation events.

Parameters:
- INPUT_WIDTH, 16, width of signed data_i (adder output width).
- OUTPUT_WIDTH, 14, width of signed data_o (DAC width).
- GAIN_WIDTH, 16, width of signed gain_i.
- GAIN_FRAC, 12, fractional bits of gain_i (4096 = 1.0).
- ENV_BITS, 8, envelope resolution; full scale = 2^ENV_BITS.
- PERIOD_WIDTH, 16, width of ramp_period_i.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous reset, active-low.
- data_i  input  INPUT_WIDTH  signed sample, valid every cycle.
- gain_i  input  GAIN_WIDTH  signed gain, Q(GAIN_FRAC).
- enable_i  input  1  level: 1 = ramp feedback on, 0 = ramp off.
- ramp_period_i  input  PERIOD_WIDTH  envelope steps once every ramp_period_i+1 cycles.
- clr_sat_i  input  1  clears the saturation counter.
- data_o  output  OUTPUT_WIDTH  signed saturated output.
- sat_o  output  1  registered with data_o; high when that sample was clipped.
- state_o  output  2  0=OFF, 1=RAMP_UP, 2=ON, 3=RAMP_DOWN.
- env_o  output  ENV_BITS+1  current envelope, unsigned, 0..2^ENV_BITS.
- sat_count_o  output  16  saturation event count (see Optional Feature).

Behaviour:
- Reset (async, rst_ni low): all pipeline regs 0, data_o=0, sat_o=0, state OFF, env=0, step counter 0, sat_count_o=0. Reset mid-ramp aborts immediately to OFF.
- Pipeline, latency 3 cycles from data_i/gain_i to data_o:
  - S1: p1 = data_i*gain_i, full 32-bit signed, registered.
  - S2: p2 = p1*env, env as unsigned ENV_BITS+1 (zero-extended), 41-bit signed, registered. Uses env value in that cycle.
  - S3: arithmetic shift right by GAIN_FRAC+ENV_BITS (floor, no rounding). Clamp to [-2^(OUTPUT_WIDTH-1), 2^(OUTPUT_WIDTH-1)-1]. Register into data_o; sat_o=1 if clamped.
- Step timer: counts 0..ramp_period_i while in RAMP_UP/RAMP_DOWN; a step fires when count==ramp_period_i, then count resets to 0. ramp_period_i=0 steps every cycle. Count is cleared on every state change.
- FSM:
  - OFF: env=0. enable_i=1 -> RAMP_UP.
  - RAMP_UP: env+=1 per step. When env reaches 2^ENV_BITS -> ON. enable_i=0 -> RAMP_DOWN, env kept.
  - ON: env=2^ENV_BITS. enable_i=0 -> RAMP_DOWN.
  - RAMP_DOWN: env-=1 per step. When env reaches 0 -> OFF. enable_i=1 -> RAMP_UP, env kept.
- Simultaneous events:
  - A step and an enable change in the same cycle: the transition wins; no env change that cycle.
- Envelope bounds:
  - env never wraps; clamped at 0 and 2^ENV_BITS.
- Input changes:
  - gain_i/ramp_period_i changes take effect immediately; no glitch protection required.
- state_o/env_o are registered and reflect the current FSM.

Optional Feature:
- Macro FB_OUTPUT_SAT_COUNT_EN.
- Defined:
  - sat_count_o increments on every cycle where sat_o is 1, saturating at 0xFFFF.
  - clr_sat_i=1 sets it to 0; clear has priority over increment in the same cycle.
- Undefined:
  - Counter not instantiated; sat_count_o tied to 0; clr_sat_i ignored.

Test Plan:
- Pass-through: enable_i=1, ramp_period_i=0, wait for state ON (env=256). gain_i=4096, data_i=1000 -> data_o=1000 exactly 3 cycles later, sat_o=0. data_i=-1000 -> -1000.
- Saturation: env=256, gain_i=4096. data_i=32767 -> data_o=8191, sat_o=1. data_i=-32768 -> data_o=-8192, sat_o=1. With macro defined: sat_count_o=2, then clr_sat_i pulse -> 0.
- Ramp up: ramp_period_i=3, enable_i rises at t0 -> state RAMP_UP. env increments every 4 cycles; state ON and env=256 at t0+1+1024 (±1 cycle per FSM registration). data_i=4000, gain 4096: data_o follows floor(4000*env/256).
- Reversal: during RAMP_UP, drop enable_i at env=100 -> RAMP_DOWN, env 99..0, then OFF with data_o=0. Re-raise at env=50 -> RAMP_UP from 50.
- Reset mid-ramp: assert rst_ni low at env=120 in RAMP_UP -> env=0, state OFF, data_o=0, sat_o=0 immediately (asynchronous), held through release.
- Negative gain/floor: env=256, gain_i=-2048, data_i=3 -> data_o=-2 (floor of -1.5).
